// File: rtl/mem_addr_gen_pkg.sv
// Shared definitions for the mem_addr_gen block.
//
// Contents:
//   ADDR_WIDTH_DEFAULT - default width of the generated address (33)
//   PASS_WIDTH_DEFAULT - default width of the pass counters (16)
//   state_t            - controller state encoding
//
// Build option: MEM_ADDR_GEN_GAP_EN adds the GAP state, which inserts one
// idle cycle after every transfer. Without it the GAP state does not exist.
package mem_addr_gen_pkg;

    localparam int ADDR_WIDTH_DEFAULT = 33;
    localparam int PASS_WIDTH_DEFAULT = 16;

`ifdef MEM_ADDR_GEN_GAP_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_GAP  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
`endif

endpackage

// File: rtl/mem_addr_gen_if.sv
// Command and address-stream bundle of the mem_addr_gen block.
//
// Signals:
//   start, abort          - sequence control (host -> generator)
//   start_addr, end_addr  - inclusive address range of one pass
//   pass_count            - number of passes to run
//   addr_out, addr_valid  - generated address stream (generator -> sink)
//   addr_ready            - sink accepts the current address
//   busy, done, pass_idx  - status (generator -> host)
//
// Modports:
//   master - host/sink side: drives commands and addr_ready
//   slave  - the generator itself
//
// Build option: MEM_ADDR_GEN_GAP_EN (no effect on this file).
interface mem_addr_gen_if
    import mem_addr_gen_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
    parameter int PASS_WIDTH = PASS_WIDTH_DEFAULT
);

    logic                  start;
    logic                  abort;
    logic [ADDR_WIDTH-1:0] start_addr;
    logic [ADDR_WIDTH-1:0] end_addr;
    logic [PASS_WIDTH-1:0] pass_count;
    logic [ADDR_WIDTH-1:0] addr_out;
    logic                  addr_valid;
    logic                  addr_ready;
    logic                  busy;
    logic                  done;
    logic [PASS_WIDTH-1:0] pass_idx;

    modport master (
        output start, abort, start_addr, end_addr, pass_count, addr_ready,
        input  addr_out, addr_valid, busy, done, pass_idx
    );

    modport slave (
        input  start, abort, start_addr, end_addr, pass_count, addr_ready,
        output addr_out, addr_valid, busy, done, pass_idx
    );

endinterface

// File: rtl/mem_addr_wrap_cnt.sv
// Loadable, enabled address counter that wraps modulo 2^ADDR_WIDTH and
// flags when it sits on a programmed end value.
//
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-low reset, clears the count
//   load     - load load_val (takes priority over en)
//   load_val - value to load
//   en       - increment by one, wrapping from all-ones to zero
//   end_val  - value compared against the count
//   count    - current count
//   at_end   - count equals end_val
//
// Build option: MEM_ADDR_GEN_GAP_EN (no effect on this file).
module mem_addr_wrap_cnt
    import mem_addr_gen_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_val,
    input  logic                  en,
    input  logic [ADDR_WIDTH-1:0] end_val,
    output logic [ADDR_WIDTH-1:0] count,
    output logic                  at_end
);

    // The natural overflow of the adder gives the modulo-2^N wrap.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= count + ADDR_WIDTH'(1);
        end
    end

    assign at_end = (count == end_val);

endmodule

// File: rtl/mem_addr_gen.sv
// Multi-pass address sequence generator. On start it latches an inclusive
// address range and a pass count, then streams every address of the range
// (wrapping through zero when end_addr < start_addr) once per pass over a
// valid/ready handshake. A one-cycle done pulse marks the end of the final
// pass; abort returns to IDLE without a done pulse.
//
// Ports:
//   clk - clock, rising edge
//   rst - synchronous active-low reset, overrides every other input
//   bus - mem_addr_gen_if.slave: commands, address stream and status
//
// Build option: MEM_ADDR_GEN_GAP_EN inserts one GAP cycle (addr_valid=0)
// after every transfer except the one that completes the final pass.
module mem_addr_gen
    import mem_addr_gen_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
    parameter int PASS_WIDTH = PASS_WIDTH_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    mem_addr_gen_if.slave bus
);

    state_t                state;
    logic [ADDR_WIDTH-1:0] start_lat;
    logic [ADDR_WIDTH-1:0] end_lat;
    logic [PASS_WIDTH-1:0] passes_lat;
    logic [PASS_WIDTH-1:0] pass_idx;
    logic                  addr_valid;
    logic                  busy;
    logic                  done;

    logic                  xfer;
    logic                  last_pass;
    logic                  cnt_load;
    logic                  cnt_en;
    logic [ADDR_WIDTH-1:0] cnt_load_val;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  at_end;

    assign xfer      = addr_valid && bus.addr_ready;
    // passes_lat is never zero while in RUN, so the subtraction cannot wrap there.
    assign last_pass = (pass_idx == passes_lat - PASS_WIDTH'(1));

    // Counter control is decoded from the same state and inputs the FSM sees,
    // so the address and the FSM registers move on the same edge.
    always_comb begin
        cnt_load     = 1'b0;
        cnt_en       = 1'b0;
        cnt_load_val = bus.start_addr;
        case (state)
            ST_IDLE: begin
                if (bus.start && (bus.pass_count != '0)) begin
                    cnt_load = 1'b1;
                end
            end
            ST_RUN: begin
                if (!bus.abort && xfer) begin
                    if (at_end) begin
                        if (!last_pass) begin
                            cnt_load     = 1'b1;
                            cnt_load_val = start_lat;
                        end
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    mem_addr_wrap_cnt #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .end_val  (end_lat),
        .count    (addr),
        .at_end   (at_end)
    );

    // Latched configuration: only read after start has loaded it, so it
    // carries no reset.
    always_ff @(posedge clk) begin
        if ((state == ST_IDLE) && bus.start) begin
            start_lat  <= bus.start_addr;
            end_lat    <= bus.end_addr;
            passes_lat <= bus.pass_count;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            pass_idx   <= '0;
            addr_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        pass_idx <= '0;
                        busy     <= 1'b1;
                        if (bus.pass_count == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= ST_RUN;
                            addr_valid <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.abort) begin
                        state      <= ST_IDLE;
                        addr_valid <= 1'b0;
                        busy       <= 1'b0;
                    end else if (xfer) begin
                        if (at_end && last_pass) begin
                            state      <= ST_DONE;
                            addr_valid <= 1'b0;
                            done       <= 1'b1;
                        end else begin
                            if (at_end) begin
                                pass_idx <= pass_idx + PASS_WIDTH'(1);
                            end
`ifdef MEM_ADDR_GEN_GAP_EN
                            state      <= ST_GAP;
                            addr_valid <= 1'b0;
`endif
                        end
                    end
                end
`ifdef MEM_ADDR_GEN_GAP_EN
                ST_GAP: begin
                    if (bus.abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state      <= ST_RUN;
                        addr_valid <= 1'b1;
                    end
                end
`endif
                // DONE always lasts one cycle; abort here leads to the same place.
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state      <= ST_IDLE;
                    addr_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.addr_out   = addr;
    assign bus.addr_valid = addr_valid;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.pass_idx   = pass_idx;

endmodule

// File: tb/tb_mem_addr_gen.sv
// Self-checking bench for mem_addr_gen (4-bit addresses so wrap-around is
// exercised often). Table-driven range runs, directed corner sequences and
// randomized runs checked against a queue-based model of the address list.
// Build option: MEM_ADDR_GEN_GAP_EN changes the expected handshake timing.
module tb_mem_addr_gen;

    localparam int AW    = 4;
    localparam int PW    = 16;
    localparam int LIMIT = 2000;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int checks   = 0;
    int failures = 0;

    int obs_a[$];
    int obs_p[$];

    mem_addr_gen_if #(.ADDR_WIDTH(AW), .PASS_WIDTH(PW)) bus();

    mem_addr_gen #(.ADDR_WIDTH(AW), .PASS_WIDTH(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timeout after %0d cycles, expected done", name, LIMIT);
    endtask

    task automatic issue_start(input int s, input int e, input int pc);
        bus.start_addr = AW'(s);
        bus.end_addr   = AW'(e);
        bus.pass_count = PW'(pc);
        bus.start      = 1'b1;
        step();
        bus.start      = 1'b0;
    endtask

    // Runs a sequence with ready asserted until done; returns beats seen.
    task automatic wait_done(input string name, output int beats);
        beats = 0;
        bus.addr_ready = 1'b1;
        for (int c = 0; c < LIMIT; c++) begin
            if (bus.done) return;
            if (bus.addr_valid) beats++;
            step();
        end
        timeout(name);
    endtask

    // Model: the expected transfer list is every address from s to e
    // (inclusive, modulo 2^AW), repeated pc times, tagged with its pass.
    task automatic run_checked(input int s, input int e, input int pc, input int ready_pct,
                               input bit noise, output int beats, output int sum,
                               output int done_lat);
        int  exp_a[$];
        int  exp_p[$];
        int  a;
        bit  prev_xfer;
        bit  rdy;
        bit  finished;
        beats = 0; sum = 0; done_lat = 0; prev_xfer = 0; finished = 0;
        obs_a.delete();
        obs_p.delete();
        for (int p = 0; p < pc; p++) begin
            a = s;
            while (1) begin
                exp_a.push_back(a);
                exp_p.push_back(p);
                if (a == e) break;
                a = (a + 1) % (1 << AW);
            end
        end
        issue_start(s, e, pc);
        for (int cyc = 1; cyc <= LIMIT; cyc++) begin
            if (bus.done) begin
                check("done_early", 64'(exp_a.size()), 0);
                check("valid_in_done", 64'(bus.addr_valid), 0);
                done_lat = cyc;
                finished = 1;
                break;
            end
            check("busy_run", 64'(bus.busy), 1);
            if (bus.addr_valid) begin
                if (exp_a.size() == 0) begin
                    check("extra_beat", 64'(bus.addr_out), 64'hFFFF);
                end else begin
                    check("addr", 64'(bus.addr_out), 64'(exp_a[0]));
                    check("pass_idx", 64'(bus.pass_idx), 64'(exp_p[0]));
                end
`ifdef MEM_ADDR_GEN_GAP_EN
                if (prev_xfer) check("gap_after_xfer", 64'(bus.addr_valid), 0);
`endif
            end
            rdy = ($urandom_range(99) < 32'(ready_pct));
            bus.addr_ready = rdy;
            if (noise) begin
                bus.start      = 1'($urandom_range(1));
                bus.start_addr = AW'($urandom);
                bus.end_addr   = AW'($urandom);
                bus.pass_count = PW'($urandom_range(5));
            end
            prev_xfer = bus.addr_valid && rdy;
            if (prev_xfer && exp_a.size() > 0) begin
                beats++;
                sum += int'(bus.addr_out);
                obs_a.push_back(int'(bus.addr_out));
                obs_p.push_back(int'(bus.pass_idx));
                void'(exp_a.pop_front());
                void'(exp_p.pop_front());
            end
            step();
        end
        bus.start = 1'b0;
        if (!finished) begin
            timeout("run_checked");
        end else begin
            step();
            check("done_one_cycle", 64'(bus.done), 0);
            check("idle_after_done", 64'(bus.busy), 0);
        end
    endtask

    typedef struct {
        int s;
        int e;
        int pc;
        int beats;
        int sum;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int beats, sum, lat, exp_lat;
        int exp36[8];
        int exp36p[8];
        bit hit;

        tbl[0] = '{5, 8, 1, 4, 26};
        tbl[1] = '{14, 1, 2, 8, 60};
        tbl[2] = '{3, 3, 3, 3, 9};
        tbl[3] = '{0, 15, 1, 16, 120};
        tbl[4] = '{15, 0, 1, 2, 15};
        tbl[5] = '{9, 10, 2, 4, 38};
        exp36  = '{14, 15, 0, 1, 14, 15, 0, 1};
        exp36p = '{0, 0, 0, 0, 1, 1, 1, 1};

        bus.start = 0; bus.abort = 0; bus.addr_ready = 0;
        bus.start_addr = '0; bus.end_addr = '0; bus.pass_count = '0;

        // Reset state
        step(); step();
        check("rst_addr", 64'(bus.addr_out), 0);
        check("rst_valid", 64'(bus.addr_valid), 0);
        check("rst_busy", 64'(bus.busy), 0);
        check("rst_done", 64'(bus.done), 0);
        check("rst_pass_idx", 64'(bus.pass_idx), 0);
        rst = 1'b1;
        step();

        // Table of ranges, ready always high
        foreach (tbl[i]) begin
            run_checked(tbl[i].s, tbl[i].e, tbl[i].pc, 100, 0, beats, sum, lat);
`ifdef MEM_ADDR_GEN_GAP_EN
            exp_lat = 2 * tbl[i].beats;
`else
            exp_lat = tbl[i].beats + 1;
`endif
            check("tbl_beats", 64'(beats), 64'(tbl[i].beats));
            check("tbl_sum", 64'(sum), 64'(tbl[i].sum));
            check("tbl_done_latency", 64'(lat), 64'(exp_lat));
            if (obs_p.size() > 0) check("tbl_last_pass", 64'(obs_p[$]), 64'(tbl[i].pc - 1));
            step();
        end

        // Explicit wrapped two-pass sequence
        run_checked(14, 1, 2, 100, 0, beats, sum, lat);
        check("wrap_count", 64'(obs_a.size()), 8);
        for (int i = 0; i < 8 && i < obs_a.size(); i++) begin
            check("wrap_seq_addr", 64'(obs_a[i]), 64'(exp36[i]));
            check("wrap_seq_pass", 64'(obs_p[i]), 64'(exp36p[i]));
        end
        step();

        // Backpressure: hold ready low for 3 cycles at address 6
        issue_start(5, 8, 1);
        bus.addr_ready = 1'b1;
        hit = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.addr_valid && bus.addr_out == AW'(6)) begin hit = 1; break; end
            step();
        end
        check("bp_reached_6", 64'(hit), 1);
        bus.addr_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("bp_hold_addr", 64'(bus.addr_out), 6);
            check("bp_hold_valid", 64'(bus.addr_valid), 1);
            step();
        end
        check("bp_still_6", 64'(bus.addr_out), 6);
        bus.addr_ready = 1'b1;
        step();
`ifdef MEM_ADDR_GEN_GAP_EN
        check("bp_gap", 64'(bus.addr_valid), 0);
        step();
`endif
        check("bp_next_7", 64'(bus.addr_out), 7);
        wait_done("bp", beats);
        check("bp_remaining", 64'(beats), 2);
        step(); step();

        // Zero passes: straight to DONE, no address
        issue_start(5, 8, 0);
        check("zero_done", 64'(bus.done), 1);
        check("zero_valid", 64'(bus.addr_valid), 0);
        step();
        check("zero_done_end", 64'(bus.done), 0);
        check("zero_idle", 64'(bus.busy), 0);
        check("zero_valid2", 64'(bus.addr_valid), 0);
        step();

        // Abort coincident with the transfer of 7
        issue_start(5, 8, 1);
        bus.addr_ready = 1'b1;
        hit = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.addr_valid && bus.addr_out == AW'(7)) begin hit = 1; break; end
            step();
        end
        check("abort_reached_7", 64'(hit), 1);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("abort_valid", 64'(bus.addr_valid), 0);
        check("abort_busy", 64'(bus.busy), 0);
        check("abort_done", 64'(bus.done), 0);
        for (int c = 0; c < 3; c++) begin
            check("abort_no_done", 64'(bus.done), 0);
            step();
        end
        issue_start(5, 8, 1);
        check("restart_addr", 64'(bus.addr_out), 5);
        check("restart_valid", 64'(bus.addr_valid), 1);
        wait_done("restart", beats);
        check("restart_beats", 64'(beats), 4);
        step(); step();

        // Reset mid-run with start asserted
        issue_start(5, 8, 1);
        bus.addr_ready = 1'b0;
        step();
        rst = 1'b0;
        bus.start = 1'b1;
        step();
        check("mid_rst_addr", 64'(bus.addr_out), 0);
        check("mid_rst_valid", 64'(bus.addr_valid), 0);
        check("mid_rst_busy", 64'(bus.busy), 0);
        check("mid_rst_done", 64'(bus.done), 0);
        check("mid_rst_pass", 64'(bus.pass_idx), 0);
        rst = 1'b1;
        bus.start = 1'b0;
        step();
        check("post_rst_idle", 64'(bus.busy), 0);

        // Start while busy is ignored
        issue_start(5, 8, 1);
        bus.start_addr = AW'(0);
        bus.end_addr   = AW'(2);
        bus.pass_count = PW'(3);
        bus.start      = 1'b1;
        step();
        bus.start = 1'b0;
        check("busy_start_addr", 64'(bus.addr_out), 5);
        check("busy_start_pass", 64'(bus.pass_idx), 0);
        wait_done("busy_start", beats);
        check("busy_start_beats", 64'(beats), 4);
        step(); step();

        // Randomized runs with random backpressure and input noise
        for (int i = 0; i < 25; i++) begin
            run_checked(int'($urandom_range(15)), int'($urandom_range(15)),
                        int'($urandom_range(1, 3)), int'($urandom_range(30, 100)),
                        1, beats, sum, lat);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_addr_gen.md
MEM_ADDR_GEN -- requirements
Module: mem_addr_gen

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 33, the width of the generated address.
REQ-002 SHALL have parameter PASS_WIDTH, default 16, the width of the pass counters.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a sequence; honoured only in IDLE.
REQ-006 SHALL have port abort  input  1  terminates a running sequence.
REQ-007 SHALL have port start_addr  input  ADDR_WIDTH  first address of each pass.
REQ-008 SHALL have port end_addr  input  ADDR_WIDTH  last address of each pass, inclusive.
REQ-009 SHALL have port pass_count  input  PASS_WIDTH  number of passes to run.
REQ-010 SHALL have port addr_out  output  ADDR_WIDTH  current address, feeding the lfsr_crc data_in port.
REQ-011 SHALL have port addr_valid  output  1  addr_out is valid.
REQ-012 SHALL have port addr_ready  input  1  downstream accepts the address.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse when all passes complete.
REQ-015 SHALL have port pass_idx  output  PASS_WIDTH  index of the current pass, starting at 0.

Function
REQ-016 SHALL implement the states IDLE, RUN, GAP and DONE.
REQ-017 In IDLE, start=1 SHALL latch start_addr, end_addr and pass_count, then enter RUN on the next cycle with addr_out=start_addr and pass_idx=0.
REQ-018 If the latched pass_count=0, start SHALL go IDLE->DONE with no address issued.
REQ-019 In RUN, addr_valid SHALL be 1, so the first addr_valid appears 1 cycle after start.
REQ-020 A beat is transferred when addr_valid&addr_ready are both 1; addr_out SHALL hold stable until that transfer.
REQ-021 After each transfer, addr_out SHALL increment by 1, modulo 2^ADDR_WIDTH.
REQ-022 If end_addr<start_addr, the sequence SHALL wrap from all-ones to 0 and continue up to end_addr.
REQ-023 A transfer with addr_out==end_addr SHALL end the pass; if pass_idx==pass_count-1, the block SHALL enter DONE, otherwise pass_idx SHALL increment and addr_out SHALL reload start_addr.
REQ-024 When start_addr==end_addr, each pass SHALL be exactly one beat.
REQ-025 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-026 abort=1 in RUN, GAP or DONE SHALL force IDLE on the next cycle, with addr_valid=0 and no done pulse; abort SHALL take precedence over a simultaneous transfer.
REQ-027 start SHALL be ignored while busy=1.
REQ-028 Changes on start_addr, end_addr or pass_count during a sequence SHALL have no effect until the next start.

Reset
REQ-029 rst=0 at a clock edge SHALL put the block in IDLE with addr_out=0, addr_valid=0, busy=0, done=0 and pass_idx=0.
REQ-030 Reset SHALL override all other inputs, including mid-sequence.

Configuration
REQ-031 With macro MEM_ADDR_GEN_GAP_EN defined, each transfer SHALL be followed by one GAP cycle with addr_valid=0 before the next address is presented; the transfer that ends the final pass SHALL go straight to DONE.
REQ-032 Without MEM_ADDR_GEN_GAP_EN, the GAP state SHALL NOT be generated, and back-to-back transfers SHALL be possible every cycle.

Structure
REQ-033 Package mem_addr_gen_pkg SHALL hold the state enum typedef and the default ADDR_WIDTH and PASS_WIDTH constants.
REQ-034 The block SHALL contain one sub-module, mem_addr_wrap_cnt: a loadable, enabled, wrapping address counter with an end-match flag.

Verification
REQ-035 start_addr=5, end_addr=8, pass_count=1, addr_ready=1 -> addresses 5,6,7,8 on consecutive cycles; done exactly 1 cycle after the transfer of 8.
REQ-036 ADDR_WIDTH=4, start_addr=14, end_addr=1, pass_count=2 -> addresses 14,15,0,1,14,15,0,1; pass_idx 0 then 1; one done pulse.
REQ-037 addr_ready held 0 for 3 cycles at address 6 -> addr_out stays 6 and addr_valid stays 1 throughout; no address skipped.
REQ-038 pass_count=0 -> done 1 cycle after start, with addr_valid never 1.
REQ-039 abort asserted on the same cycle as the transfer of 7 in a 5..8 run -> IDLE next cycle, no done pulse; a following start restarts at 5.
REQ-040 rst=0 mid-run, then start while busy -> all outputs at their reset values; the start while busy is ignored. With MEM_ADDR_GEN_GAP_EN, addr_valid alternates 1,0 over a 5..8 run.
